// File: rtl/adc_c2h_packer.sv
// Packs parallel ADC frames into 128-bit AXI-Stream beats (four sign-extended 32-bit lanes each),
// with decimation, channel masking, drop accounting and zero-fill of partial packets on stop.
module adc_c2h_packer #(
  parameter int unsigned ADC_CHANNELS   = 4,
  parameter int unsigned ADC_DATA_WIDTH = 18,
  parameter int unsigned C_DATA_WIDTH   = 128,
  parameter int unsigned PKT_SAMPLES    = 64,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                                   axi_aclk,
  input  logic                                   rst,
  input  logic                                   acq_en,
  input  logic [15:0]                            decim_ratio,
  input  logic [ADC_CHANNELS-1:0]                channel_mask,
  input  logic                                   sample_valid,
  input  logic [ADC_CHANNELS*ADC_DATA_WIDTH-1:0] adc_data,
  output logic [C_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]              m_axis_tkeep,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  input  logic                                   m_axis_tready,
  output logic                                   overflow,
  output logic [15:0]                            drop_count,
  output logic                                   busy
);

  localparam int unsigned Bps    = (ADC_CHANNELS + 3) / 4;
  localparam int unsigned NLanes = Bps * 4;
  localparam int unsigned SW     = (PKT_SAMPLES > 1) ? $clog2(PKT_SAMPLES) : 1;
  localparam int unsigned BW     = (Bps > 1) ? $clog2(Bps) : 1;
  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);

  localparam logic [SW-1:0] SampLast = SW'(PKT_SAMPLES - 1);
  localparam logic [BW-1:0] BeatLast = BW'(Bps - 1);
  localparam logic [AW-1:0] PtrLast  = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] OccMax   = CW'(FIFO_DEPTH - Bps);
  localparam logic [CW-1:0] Depth    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StWrite, StFlush} state_e;

  state_e                  st_q;
  logic [15:0]             ratio_q, dec_cnt_q, drop_q;
  logic [SW-1:0]           samp_q;
  logic [BW-1:0]           beat_q;
  logic [NLanes*32-1:0]    hold_q, lanes;
  logic                    ovf_q;

  logic [C_DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q, occ;
  logic                    tvalid_q, tlast_q;
  logic [C_DATA_WIDTH-1:0] tdata_q, wr_data;

  logic keep, beat_done, pkt_end, room, wr_en, pop, drop_evt;

  // Masked, sign-extended lanes; lanes past the last channel stay zero.
  always_comb begin
    lanes = '0;
    for (int i = 0; i < int'(ADC_CHANNELS); i++) begin
      if (channel_mask[i]) begin
        lanes[i*32 +: 32] = 32'(signed'(adc_data[i*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]));
      end
    end
  end

  // Occupancy includes the output register so total capacity is FIFO_DEPTH beats.
  assign occ       = cnt_q + CW'(tvalid_q);
  assign room      = occ <= OccMax;
  assign keep      = sample_valid && (dec_cnt_q == '0);
  assign beat_done = beat_q == BeatLast;
  assign pkt_end   = beat_done && (samp_q == SampLast);
  assign drop_evt  = ((st_q == StRun) && acq_en && keep && !room) || ((st_q == StWrite) && keep);

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    if (st_q == StWrite) begin
      wr_en   = 1'b1;
      wr_data = hold_q[int'(beat_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
    end else if (st_q == StFlush) begin
      wr_en = occ < Depth;
    end
  end

  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) begin
      st_q      <= StIdle;
      ratio_q   <= 16'd1;
      dec_cnt_q <= '0;
      samp_q    <= '0;
      beat_q    <= '0;
      hold_q    <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      if ((st_q == StRun || st_q == StWrite) && sample_valid) begin
        dec_cnt_q <= (dec_cnt_q == ratio_q - 16'd1) ? '0 : dec_cnt_q + 16'd1;
      end
      if (drop_evt) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
      unique case (st_q)
        StIdle: begin
          if (acq_en) begin
            ratio_q   <= (decim_ratio == '0) ? 16'd1 : decim_ratio;
            dec_cnt_q <= '0;
            samp_q    <= '0;
            beat_q    <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
            st_q      <= StRun;
          end
        end
        StRun: begin
          beat_q <= '0;
          if (!acq_en) begin
            st_q <= (samp_q == '0) ? StIdle : StFlush;
          end else if (keep && room) begin
            hold_q <= lanes;
            st_q   <= StWrite;
          end
        end
        StWrite: begin
          if (beat_done) begin
            beat_q <= '0;
            samp_q <= (samp_q == SampLast) ? '0 : samp_q + 1'b1;
            st_q   <= StRun;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        StFlush: begin
          if (wr_en) begin
            if (beat_done) begin
              beat_q <= '0;
              samp_q <= (samp_q == SampLast) ? '0 : samp_q + 1'b1;
              if (pkt_end) st_q <= StIdle;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  // FWFT buffer: memory ring plus a registered output stage that holds still under backpressure.
  assign pop = (cnt_q != '0) && (!tvalid_q || m_axis_tready);

  always_ff @(posedge axi_aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {pkt_end, wr_data};
  end

  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr_en) - CW'(pop);
      if (pop) begin
        tvalid_q           <= 1'b1;
        {tlast_q, tdata_q} <= mem_q[rd_ptr_q];
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tkeep  = '1;
  assign overflow      = ovf_q;
  assign drop_count    = drop_q;
  assign busy          = st_q != StIdle;

endmodule

// File: doc/adc_c2h_packer.md
# adc_c2h_packer

Packs parallel ADC sample frames into 128-bit AXI-Stream beats for an XDMA C2H channel. Each channel is sign-extended to a 32-bit lane, with four lanes per beat. Samples are grouped into fixed-length packets marked by `tlast`. The block sits between `adc_block` (after its samples are resynchronised to `axi_aclk`) and `s_axis_c2h_*`. It supports configurable channel count, packet length, decimation, channel masking, overflow accounting and clean packet termination.

## Interface
- `ADC_CHANNELS`, 4: channel count; must be even, 2..48.
- `ADC_DATA_WIDTH`, 18: bits per sample, two's complement.
- `C_DATA_WIDTH`, 128: stream width; fixed at 128 (4 lanes).
- `PKT_SAMPLES`, 64: samples per packet; must be ≥1.
- `FIFO_DEPTH`, 16: output FIFO depth in beats; power of 2, ≥ `BEATS_PER_SAMPLE`.
- Derived: `BEATS_PER_SAMPLE` = ceil(`ADC_CHANNELS`/4).
- `axi_aclk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `acq_en`, in, 1: acquisition enable, level-sensitive.
- `decim_ratio`, in, 16: keep 1 of N samples; 0 is treated as 1. Sampled on the `acq_en` rising edge.
- `channel_mask`, in, `ADC_CHANNELS`: 1 enables a channel; a masked channel's lane is forced to 0.
- `sample_valid`, in, 1: one-cycle strobe marking a new frame.
- `adc_data`, in, `ADC_CHANNELS*ADC_DATA_WIDTH`: frame; channel i is at bits [i*W +: W].
- `m_axis_tdata`, out, 128: lane j is at bits [32j +: 32].
- `m_axis_tkeep`, out, 16: constant all-ones.
- `m_axis_tvalid`, `m_axis_tlast`, out, 1: stream valid and end-of-packet.
- `m_axis_tready`, in, 1: stream ready.
- `overflow`, out, 1: sticky; a sample was dropped.
- `drop_count`, out, 16: dropped samples, saturating at 16'hFFFF.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, WRITE, FLUSH.
- **IDLE**
  - On `acq_en` = 1: latch `decim_ratio`, clear the decimation counter, the sample-in-packet counter, `overflow` and `drop_count`, then go to RUN.
- **RUN, with `sample_valid` = 1**
  - If the decimation counter ≠ 0: discard the sample; this is not a drop.
  - Otherwise, if FIFO free entries ≥ `BEATS_PER_SAMPLE`: capture masked data into the holding register and go to WRITE.
  - Otherwise: drop the sample, set `overflow`, increment `drop_count`.
  - The decimation counter advances on every `sample_valid` in RUN or WRITE and wraps at ratio−1.
- **WRITE**
  - Writes one beat per cycle, k = 0..`BEATS_PER_SAMPLE`−1; beat k carries channels 4k..4k+3.
  - Lanes beyond `ADC_CHANNELS` are 0.
  - The last beat of the sample at `PKT_SAMPLES`−1 carries `tlast` = 1; the sample counter then wraps to 0.
  - After the last beat, return to RUN.
  - A kept `sample_valid` arriving during WRITE is dropped and counted.
- **Stopping**
  - If `acq_en` = 0 in RUN with sample counter = 0: go to IDLE.
  - If `acq_en` = 0 in RUN with sample counter ≠ 0: go to FLUSH.
  - In WRITE, the `acq_en` check is deferred until the sample is complete.
- **FLUSH**
  - Writes all-zero samples, with the same beat structure, one beat per cycle while the FIFO is not full.
  - Continues until the packet's `tlast` beat is written, then goes to IDLE.
  - Re-asserting `acq_en` during FLUSH has no effect until IDLE.
- **FIFO**
  - First-word fall-through, storing {tlast, tdata}.
  - A write to a full FIFO never occurs by construction.
- **Arithmetic**
  - Lane value = sign-extend(`ADC_DATA_WIDTH` → 32) of the channel data, or 0 if the channel is masked.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `overflow`, `busy`: 0.
  - `m_axis_tdata`, `drop_count`: 0.
  - FSM: IDLE; FIFO: empty.
- Latency:
  - `sample_valid` sampled at edge t → captured at t.
  - Beat k is written at edge t+1+k.
  - `m_axis_tvalid` is high in the cycle after edge t+2, when the FIFO was empty.
- Handshake:
  - A beat transfers on `tvalid & tready`.
  - While `tready` = 0, `tdata`, `tlast` and `tvalid` are held stable.
- A simultaneous FIFO read and write in the same cycle is supported; the count is unchanged.
- Free-entry check: the registered count, evaluated in the capture cycle.
- `rst` mid-packet: the FIFO is emptied, any partial packet is discarded, `tvalid` falls asynchronously, and the FSM returns to IDLE.
- Sustained throughput: one sample per `BEATS_PER_SAMPLE`+1 cycles.

## Test plan
- **Basic packing:** `ADC_CHANNELS`=4, `PKT_SAMPLES`=4, `tready`=1; 4 samples with ch0=18'h00001, ch1=18'h20000, ch2=18'h1FFFF, ch3=0 → 4 beats with tdata=128'h00000000_0001FFFF_FFFE0000_00000001; `tlast` only on beat 4.
- **Odd lane count and masking:** `ADC_CHANNELS`=6, `channel_mask`=6'b111101 → 2 beats per sample; beat 0 lane1 = 0; beat 1 lanes 2 and 3 = 0.
- **Decimation:** `decim_ratio`=3, 9 strobes → samples 0, 3 and 6 emitted; `drop_count`=0. `decim_ratio`=0 → every sample kept.
- **Overflow under backpressure:** `FIFO_DEPTH`=4, `tready`=0, 5 samples → 4 beats buffered, `overflow`=1, `drop_count`=1. Releasing `tready` → exactly 4 beats in order.
- **Flush on stop:** `PKT_SAMPLES`=4, `acq_en` drops after 2 samples → 2 all-zero beats follow, `tlast` on the second, `busy` falls after the last FIFO write. Then stop with sample counter=0 → no fill beats.
- **Reset mid-operation:** assert `rst` with 3 beats queued and `tready`=0 → `tvalid`=0 immediately. After release, a new `acq_en` yields a packet starting at sample 0 with correct `tlast` position.
